// File: rtl/button_conditioner_pkg.sv
// Shared types and width helpers for the button conditioner.
package button_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Bits needed to hold any value from 0 up to max(a, b).
  function automatic int unsigned clog2_of_max(input int unsigned a,
                                               input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: input synchroniser, integrating debounce with
// press/release pulses, and a hold-to-auto-repeat FSM.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  input  logic i_repeat_mask,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_rpt
);

  localparam int unsigned CNT_W = clog2_of_max(STABLE_CYCLES, 1);
  localparam int unsigned RC_W  = clog2_of_max(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level;
  logic             w_level_next;
  logic             r_press;
  logic             w_press_next;
  logic             r_release;
  logic             w_release_next;

  rpt_state_t       r_state;
  rpt_state_t       w_state_next;
  logic [RC_W-1:0]  r_rc;
  logic [RC_W-1:0]  w_rc_next;
  logic             r_rpt;
  logic             w_rpt_next;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  // Integrating debounce: any cycle where s matches level restarts the count.
  always_comb begin
    w_level_next   = r_level;
    w_cnt_next     = '0;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    if (w_s != r_level) begin
      if (r_cnt == CNT_LAST) begin
        w_level_next   = w_s;
        w_press_next   = w_s;
        w_release_next = ~w_s;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // Debounce state and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  // Repeat next-state logic. It follows the level being registered on this
  // edge, so DELAY is entered on the press edge itself and the first repeat
  // lands exactly REPEAT_DELAY edges after press; a release on this edge
  // forces IDLE and suppresses any repeat due on it.
  always_comb begin
    w_state_next = r_state;
    w_rc_next    = r_rc;
    w_rpt_next   = 1'b0;
    if (!w_level_next || !i_repeat_mask) begin
      w_state_next = RPT_IDLE;
      w_rc_next    = '0;
    end else begin
      case (r_state)
        RPT_IDLE: begin
          w_state_next = RPT_DELAY;
          w_rc_next    = '0;
        end
        RPT_DELAY: begin
          if (r_rc == RC_DELAY_LAST) begin
            w_rpt_next   = 1'b1;
            w_rc_next    = '0;
            w_state_next = RPT_REPEAT;
          end else begin
            w_rc_next = r_rc + RC_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (r_rc == RC_PERIOD_LAST) begin
            w_rpt_next = 1'b1;
            w_rc_next  = '0;
          end else begin
            w_rc_next = r_rc + RC_W'(1);
          end
        end
        default: begin
          w_state_next = RPT_IDLE;
          w_rc_next    = '0;
        end
      endcase
    end
  end

  // Repeat FSM state, counter and registered repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RPT_IDLE;
      r_rc    <= '0;
      r_rpt   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rc    <= w_rc_next;
      r_rpt   <= w_rpt_next;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_rpt     = r_rpt;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel front-panel button conditioner: one independent
// synchronise/debounce/auto-repeat channel per input, plus fire = press | rpt.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CH            = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] i_in,
  input  logic [CH-1:0] i_repeat_mask,
  output logic [CH-1:0] o_level,
  output logic [CH-1:0] o_press,
  output logic [CH-1:0] o_release,
  output logic [CH-1:0] o_rpt,
  output logic [CH-1:0] o_fire
);

  logic [CH-1:0] w_press;
  logic [CH-1:0] w_rpt;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_channel (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_in          (i_in[g]),
      .i_repeat_mask (i_repeat_mask[g]),
      .o_level       (o_level[g]),
      .o_press       (w_press[g]),
      .o_release     (o_release[g]),
      .o_rpt         (w_rpt[g])
    );
  end

  assign o_press = w_press;
  assign o_rpt   = w_rpt;
  assign o_fire  = w_press | w_rpt;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_r;
  logic [3:0] mask;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] rpt;
  logic [3:0] fire;

  int unsigned n_checks;
  int unsigned n_fail;

  button_conditioner #(
    .CH            (4),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in          (in_r),
    .i_repeat_mask (mask),
    .o_level       (level),
    .o_press       (press),
    .o_release     (rel),
    .o_rpt         (rpt),
    .o_fire        (fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_level,
                           input logic [3:0] e_press, input logic [3:0] e_rel,
                           input logic [3:0] e_rpt);
    check({tag, ".level"},   level, e_level);
    check({tag, ".press"},   press, e_press);
    check({tag, ".release"}, rel,   e_rel);
    check({tag, ".rpt"},     rpt,   e_rpt);
    check({tag, ".fire"},    fire,  e_press | e_rpt);
  endtask

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop the given channels and expect release 6 edges later.
  task automatic release_and_check(input string tag, input logic [3:0] ch);
    in_r = in_r & ~ch;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all($sformatf("%s k%0d", tag, k), (k < 6) ? ch : 4'b0000,
                4'b0000, (k == 6) ? ch : 4'b0000, 4'b0000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_r     = 4'b0000;
    mask     = 4'b0000;

    // Reset state
    repeat (3) tick();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    repeat (2) tick();
    check_all("post_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Clean press on channel 0, repeat disabled
    in_r = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_all($sformatf("clean k%0d", k), (k >= 6) ? 4'b0001 : 4'b0000,
                (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
    end
    release_and_check("clean_rel", 4'b0001);

    // Bounce 1,0,1,0 at 2-cycle intervals, then settle high
    for (int p = 0; p < 4; p++) begin
      in_r = (p % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (2) begin
        tick();
        check_all($sformatf("bounce p%0d", p), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
    end
    in_r = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all($sformatf("bounce_final k%0d", k), (k >= 6) ? 4'b0001 : 4'b0000,
                (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
    end
    release_and_check("bounce_rel", 4'b0001);

    // Auto-repeat on channel 1; release lands on an edge where a repeat is due
    mask = 4'b0010;
    in_r = 4'b0010;
    for (int k = 1; k <= 48; k++) begin
      if (k == 35) in_r = 4'b0000;
      tick();
      check_all($sformatf("repeat k%0d", k),
                (k >= 6 && k < 40) ? 4'b0010 : 4'b0000,
                (k == 6) ? 4'b0010 : 4'b0000,
                (k == 40) ? 4'b0010 : 4'b0000,
                (k >= 16 && k < 40 && (k - 16) % 3 == 0) ? 4'b0010 : 4'b0000);
    end
    mask = 4'b0000;

    // Mask rises and falls during a hold on channel 2
    in_r = 4'b0100;
    for (int k = 1; k <= 40; k++) begin
      if (k == 20) mask = 4'b0100;
      if (k == 34) mask = 4'b0000;
      tick();
      check_all($sformatf("maskhold k%0d", k), (k >= 6) ? 4'b0100 : 4'b0000,
                (k == 6) ? 4'b0100 : 4'b0000, 4'b0000,
                (k == 30 || k == 33) ? 4'b0100 : 4'b0000);
    end
    release_and_check("maskhold_rel", 4'b0100);

    // Reset asserted mid-hold on channel 3, button kept pressed
    mask = 4'b1000;
    in_r = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_all($sformatf("prerst k%0d", k), (k >= 6) ? 4'b1000 : 4'b0000,
                (k == 6) ? 4'b1000 : 4'b0000, 4'b0000,
                (k == 16 || k == 19) ? 4'b1000 : 4'b0000);
    end
    #2 rst_n = 1'b0;
    #1;
    check_all("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all($sformatf("postrst k%0d", k), (k >= 6) ? 4'b1000 : 4'b0000,
                (k == 6) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000);
    end
    mask = 4'b0000;
    release_and_check("postrst_rel", 4'b1000);

    // Two channels pressed together
    in_r = 4'b1001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all($sformatf("concur k%0d", k), (k >= 6) ? 4'b1001 : 4'b0000,
                (k == 6) ? 4'b1001 : 4'b0000, 4'b0000, 4'b0000);
    end
    release_and_check("concur_rel", 4'b1001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
